// File: rtl/pipeline_pkg.sv
// Shared types and widths for the in-order pipeline registers (IF/ID and successors).
// The packet struct and its NOP value define what a bubble looks like downstream.
package pipeline_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int NUM_W  = 4;
    localparam int TYPE_W = 4;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [TYPE_W-1:0] NOP_TYPE = 4'h0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   newpc;
        logic [NUM_W-1:0]  instnum;
        logic [TYPE_W-1:0] insttype;
    } ifid_pkt_t;

    localparam ifid_pkt_t IFID_NOP_PKT = '{
        inst:     NOP_INST,
        newpc:    {PC_W{1'b0}},
        instnum:  {NUM_W{1'b0}},
        insttype: NOP_TYPE
    };

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: a valid bit plus a packet register.
// Clear wins over load so a flush can never be overridden by an incoming beat.
module pipe_slot
    import pipeline_pkg::*;
#(
    parameter type  pkt_t   = ifid_pkt_t,
    parameter pkt_t NOP_PKT = IFID_NOP_PKT
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  pkt_t din,
    output logic valid_q,
    output pkt_t pkt_q
);

    logic valid_d;
    pkt_t pkt_d;

    // Next-state select for the slot: clear to NOP, load, or hold.
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (clear) begin
            valid_d = 1'b0;
            pkt_d   = NOP_PKT;
        end else if (load) begin
            valid_d = 1'b1;
            pkt_d   = din;
        end else begin
            valid_d = valid_q;
            pkt_d   = pkt_q;
        end
    end

    // Slot state register with asynchronous reset to an empty NOP slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pkt_q   <= NOP_PKT;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

endmodule

// File: rtl/pipeline_reg_ifid_skid.sv
// IF->ID pipeline register with a main slot (M) feeding ID and a skid slot (S)
// that absorbs the in-flight beat when ID stalls, so if_ready is purely registered.
module pipeline_reg_ifid_skid #(
    parameter int                 INST_W   = pipeline_pkg::INST_W,
    parameter int                 PC_W     = pipeline_pkg::PC_W,
    parameter int                 NUM_W    = pipeline_pkg::NUM_W,
    parameter int                 TYPE_W   = pipeline_pkg::TYPE_W,
    parameter logic [INST_W-1:0]  NOP_INST = pipeline_pkg::NOP_INST,
    parameter logic [TYPE_W-1:0]  NOP_TYPE = pipeline_pkg::NOP_TYPE,
    parameter int                 CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [INST_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_newpc,
    input  logic [NUM_W-1:0]  if_instnum,
    input  logic [TYPE_W-1:0] if_insttype,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_newpc,
    output logic [NUM_W-1:0]  id_instnum,
    output logic [TYPE_W-1:0] id_insttype,
    output logic [CNT_W-1:0]  bubble_count
);

    import pipeline_pkg::*;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   newpc;
        logic [NUM_W-1:0]  instnum;
        logic [TYPE_W-1:0] insttype;
    } slot_pkt_t;

    localparam slot_pkt_t SLOT_NOP = slot_pkt_t'({NOP_INST, {PC_W{1'b0}}, {NUM_W{1'b0}}, NOP_TYPE});

    logic       accept_s;
    logic       consume_s;
    slot_pkt_t  if_pkt_s;

    logic       m_valid_q, s_valid_q;
    slot_pkt_t  m_pkt_q, s_pkt_q;
    logic       m_load_s, m_clear_s, s_load_s, s_clear_s;
    slot_pkt_t  m_din_s;
    logic       m_valid_d, s_valid_d;

    logic             if_ready_q, if_ready_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    assign accept_s  = if_valid & if_ready_q;
    assign consume_s = m_valid_q & id_ready;
    assign if_pkt_s  = slot_pkt_t'({if_inst, if_newpc, if_instnum, if_insttype});

    // Slot steering: flush kills everything, otherwise S drains into M ahead of new beats.
    always_comb begin
        m_load_s  = 1'b0;
        m_clear_s = 1'b0;
        s_load_s  = 1'b0;
        s_clear_s = 1'b0;
        m_din_s   = if_pkt_s;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_clear_s = 1'b1;
            s_clear_s = 1'b1;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || consume_s) begin
            if (s_valid_q) begin
                m_load_s  = 1'b1;
                m_din_s   = s_pkt_q;
                m_valid_d = 1'b1;
                if (accept_s) begin
                    s_load_s  = 1'b1;
                    s_valid_d = 1'b1;
                end else begin
                    s_clear_s = 1'b1;
                    s_valid_d = 1'b0;
                end
            end else begin
                s_valid_d = 1'b0;
                if (accept_s) begin
                    m_load_s  = 1'b1;
                    m_valid_d = 1'b1;
                end else begin
                    m_clear_s = 1'b1;
                    m_valid_d = 1'b0;
                end
            end
        end else begin
            // M is held; if_ready guarantees S is empty whenever accept is high.
            m_valid_d = 1'b1;
            if (accept_s) begin
                s_load_s  = 1'b1;
                s_valid_d = 1'b1;
            end else begin
                s_valid_d = s_valid_q;
            end
        end
    end

    // Ready and saturating bubble counter, both judged on the post-edge slot state.
    always_comb begin
        if_ready_d = !s_valid_d;
        bubble_d   = bubble_q;
        if (!m_valid_d) begin
            if (&bubble_q) begin
                bubble_d = bubble_q;
            end else begin
                bubble_d = bubble_q + CNT_W'(1);
            end
        end else begin
            bubble_d = bubble_q;
        end
    end

    // Registered ready and bubble counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_ready_q <= 1'b1;
            bubble_q   <= {CNT_W{1'b0}};
        end else begin
            if_ready_q <= if_ready_d;
            bubble_q   <= bubble_d;
        end
    end

    pipe_slot #(
        .pkt_t   (slot_pkt_t),
        .NOP_PKT (SLOT_NOP)
    ) u_slot_m (
        .clock   (clock),
        .reset   (reset),
        .load    (m_load_s),
        .clear   (m_clear_s),
        .din     (m_din_s),
        .valid_q (m_valid_q),
        .pkt_q   (m_pkt_q)
    );

    pipe_slot #(
        .pkt_t   (slot_pkt_t),
        .NOP_PKT (SLOT_NOP)
    ) u_slot_s (
        .clock   (clock),
        .reset   (reset),
        .load    (s_load_s),
        .clear   (s_clear_s),
        .din     (if_pkt_s),
        .valid_q (s_valid_q),
        .pkt_q   (s_pkt_q)
    );

    assign if_ready     = if_ready_q;
    assign id_valid     = m_valid_q;
    assign id_inst      = m_pkt_q.inst;
    assign id_newpc     = m_pkt_q.newpc;
    assign id_instnum   = m_pkt_q.instnum;
    assign id_insttype  = m_pkt_q.insttype;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipeline_reg_ifid_skid.sv
// Directed, table-driven bench for pipeline_reg_ifid_skid; a second instance with a
// 3-bit bubble counter shares the inputs to exercise saturation.
module tb_pipeline_reg_ifid_skid;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_newpc;
    logic [3:0]  if_instnum;
    logic [3:0]  if_insttype;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_newpc;
    logic [3:0]  id_instnum;
    logic [3:0]  id_insttype;
    logic [15:0] bubble_count;

    logic        c3_if_ready;
    logic        c3_id_valid;
    logic [31:0] c3_id_inst;
    logic [31:0] c3_id_newpc;
    logic [3:0]  c3_id_instnum;
    logic [3:0]  c3_id_insttype;
    logic [2:0]  c3_bubble_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    pipeline_reg_ifid_skid dut (
        .clock(clock), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_newpc(if_newpc), .if_instnum(if_instnum), .if_insttype(if_insttype),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_newpc(id_newpc), .id_instnum(id_instnum), .id_insttype(id_insttype),
        .bubble_count(bubble_count)
    );

    pipeline_reg_ifid_skid #(.CNT_W(3)) dut_c3 (
        .clock(clock), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_ready(c3_if_ready),
        .if_inst(if_inst), .if_newpc(if_newpc), .if_instnum(if_instnum), .if_insttype(if_insttype),
        .id_valid(c3_id_valid), .id_ready(id_ready),
        .id_inst(c3_id_inst), .id_newpc(c3_id_newpc), .id_instnum(c3_id_instnum), .id_insttype(c3_id_insttype),
        .bubble_count(c3_bubble_count)
    );

    typedef struct {
        logic        iv;
        logic        ir;
        logic        fl;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [3:0]  num;
        logic [3:0]  typ;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [3:0]  e_num;
        logic [3:0]  e_typ;
        logic        e_ready;
        logic [15:0] e_bub;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic iv, input logic ir, input logic fl,
                                input logic [31:0] inst, input logic [31:0] pc,
                                input logic [3:0] num, input logic [3:0] typ,
                                input logic ev, input logic [31:0] einst, input logic [31:0] epc,
                                input logic [3:0] enm, input logic [3:0] etyp,
                                input logic erdy, input logic [15:0] ebub);
        vec_t v;
        v.iv = iv; v.ir = ir; v.fl = fl;
        v.inst = inst; v.pc = pc; v.num = num; v.typ = typ;
        v.e_valid = ev; v.e_inst = einst; v.e_pc = epc; v.e_num = enm; v.e_typ = etyp;
        v.e_ready = erdy; v.e_bub = ebub;
        return v;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ir, input logic fl, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [3:0] num, input logic [3:0] typ);
        if_valid = iv; id_ready = ir; flush = fl;
        if_inst = inst; if_newpc = pc; if_instnum = num; if_insttype = typ;
    endtask

    initial begin
        // stream 0x20080001..4, then a stall of 3 cycles, then flush scenarios
        tbl[0]  = mk(1'b1,1'b1,1'b0,32'h2008_0001,32'h04,4'd1,4'h1, 1'b1,32'h2008_0001,32'h04,4'd1,4'h1,1'b1,16'd12);
        tbl[1]  = mk(1'b1,1'b1,1'b0,32'h2008_0002,32'h08,4'd2,4'h1, 1'b1,32'h2008_0002,32'h08,4'd2,4'h1,1'b1,16'd12);
        tbl[2]  = mk(1'b1,1'b1,1'b0,32'h2008_0003,32'h0C,4'd3,4'h1, 1'b1,32'h2008_0003,32'h0C,4'd3,4'h1,1'b1,16'd12);
        tbl[3]  = mk(1'b1,1'b1,1'b0,32'h2008_0004,32'h10,4'd4,4'h1, 1'b1,32'h2008_0004,32'h10,4'd4,4'h1,1'b1,16'd12);
        tbl[4]  = mk(1'b0,1'b1,1'b0,32'h0,32'h0,4'd0,4'h0,          1'b0,32'h0,32'h0,4'd0,4'h0,1'b1,16'd13);
        tbl[5]  = mk(1'b1,1'b1,1'b0,32'h3000_0001,32'h14,4'd5,4'h2, 1'b1,32'h3000_0001,32'h14,4'd5,4'h2,1'b1,16'd13);
        tbl[6]  = mk(1'b1,1'b0,1'b0,32'h3000_0002,32'h18,4'd6,4'h2, 1'b1,32'h3000_0001,32'h14,4'd5,4'h2,1'b0,16'd13);
        tbl[7]  = mk(1'b1,1'b0,1'b0,32'h3000_0003,32'h1C,4'd7,4'h2, 1'b1,32'h3000_0001,32'h14,4'd5,4'h2,1'b0,16'd13);
        tbl[8]  = mk(1'b1,1'b0,1'b0,32'h3000_0003,32'h1C,4'd7,4'h2, 1'b1,32'h3000_0001,32'h14,4'd5,4'h2,1'b0,16'd13);
        tbl[9]  = mk(1'b1,1'b1,1'b0,32'h3000_0003,32'h1C,4'd7,4'h2, 1'b1,32'h3000_0002,32'h18,4'd6,4'h2,1'b1,16'd13);
        tbl[10] = mk(1'b1,1'b1,1'b0,32'h3000_0003,32'h1C,4'd7,4'h2, 1'b1,32'h3000_0003,32'h1C,4'd7,4'h2,1'b1,16'd13);
        tbl[11] = mk(1'b0,1'b1,1'b0,32'h0,32'h0,4'd0,4'h0,          1'b0,32'h0,32'h0,4'd0,4'h0,1'b1,16'd14);
        tbl[12] = mk(1'b1,1'b0,1'b0,32'hAAAA_0000,32'h20,4'd8,4'h3, 1'b1,32'hAAAA_0000,32'h20,4'd8,4'h3,1'b1,16'd14);
        tbl[13] = mk(1'b1,1'b0,1'b0,32'hBBBB_0000,32'h24,4'd9,4'h3, 1'b1,32'hAAAA_0000,32'h20,4'd8,4'h3,1'b0,16'd14);
        tbl[14] = mk(1'b1,1'b0,1'b1,32'hCCCC_0000,32'h28,4'd10,4'h3,1'b0,32'h0,32'h0,4'd0,4'h0,1'b1,16'd15);
        tbl[15] = mk(1'b0,1'b1,1'b0,32'h0,32'h0,4'd0,4'h0,          1'b0,32'h0,32'h0,4'd0,4'h0,1'b1,16'd16);
        tbl[16] = mk(1'b1,1'b1,1'b0,32'h1111_0000,32'h2C,4'd11,4'h3,1'b1,32'h1111_0000,32'h2C,4'd11,4'h3,1'b1,16'd16);
        tbl[17] = mk(1'b1,1'b1,1'b1,32'hDDDD_0000,32'h30,4'd12,4'h3,1'b0,32'h0,32'h0,4'd0,4'h0,1'b1,16'd17);
        tbl[18] = mk(1'b0,1'b1,1'b0,32'h0,32'h0,4'd0,4'h0,          1'b0,32'h0,32'h0,4'd0,4'h0,1'b1,16'd18);

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        #3;
        check("reset.id_valid", 80'(id_valid), 80'(1'b0));
        check("reset.if_ready", 80'(if_ready), 80'(1'b1));
        check("reset.id_inst", 80'(id_inst), 80'(32'h0));
        check("reset.bubble", 80'(bubble_count), 80'(16'd0));
        step();
        step();
        reset = 1'b0;

        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 5) begin
                check("idle5.id_valid", 80'(id_valid), 80'(1'b0));
                check("idle5.id_inst", 80'(id_inst), 80'(32'h0));
                check("idle5.if_ready", 80'(if_ready), 80'(1'b1));
                check("idle5.bubble", 80'(bubble_count), 80'(16'd5));
                check("idle5.c3_bubble", 80'(c3_bubble_count), 80'(3'd5));
            end
            if (i >= 10) begin
                check($sformatf("idle%0d.c3_sat", i), 80'(c3_bubble_count), 80'(3'd7));
            end
        end
        check("idle12.bubble", 80'(bubble_count), 80'(16'd12));

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].iv, tbl[i].ir, tbl[i].fl, tbl[i].inst, tbl[i].pc, tbl[i].num, tbl[i].typ);
            step();
            check($sformatf("row%0d.id_valid", i), 80'(id_valid), 80'(tbl[i].e_valid));
            check($sformatf("row%0d.id_inst", i), 80'(id_inst), 80'(tbl[i].e_inst));
            check($sformatf("row%0d.id_newpc", i), 80'(id_newpc), 80'(tbl[i].e_pc));
            check($sformatf("row%0d.id_instnum", i), 80'(id_instnum), 80'(tbl[i].e_num));
            check($sformatf("row%0d.id_insttype", i), 80'(id_insttype), 80'(tbl[i].e_typ));
            check($sformatf("row%0d.if_ready", i), 80'(if_ready), 80'(tbl[i].e_ready));
            check($sformatf("row%0d.bubble", i), 80'(bubble_count), 80'(tbl[i].e_bub));
            check($sformatf("row%0d.c3_all", i),
                  80'({c3_id_valid, c3_id_inst, c3_id_newpc, c3_id_instnum, c3_id_insttype, c3_if_ready, c3_bubble_count}),
                  80'({tbl[i].e_valid, tbl[i].e_inst, tbl[i].e_pc, tbl[i].e_num, tbl[i].e_typ, tbl[i].e_ready, 3'd7}));
        end

        // Reset asserted mid-stall with both slots full must clear outputs without a clock edge.
        drive(1'b1, 1'b0, 1'b0, 32'h5555_0001, 32'h40, 4'd1, 4'h5);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h5555_0002, 32'h44, 4'd2, 4'h5);
        step();
        check("full.id_inst", 80'(id_inst), 80'(32'h5555_0001));
        check("full.if_ready", 80'(if_ready), 80'(1'b0));
        #1;
        reset = 1'b1;
        #1;
        check("arst.id_valid", 80'(id_valid), 80'(1'b0));
        check("arst.id_inst", 80'(id_inst), 80'(32'h0));
        check("arst.id_newpc", 80'(id_newpc), 80'(32'h0));
        check("arst.id_instnum", 80'(id_instnum), 80'(4'd0));
        check("arst.if_ready", 80'(if_ready), 80'(1'b1));
        check("arst.bubble", 80'(bubble_count), 80'(16'd0));
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h6666_0001, 32'h50, 4'd3, 4'h6);
        step();
        check("post.id_valid", 80'(id_valid), 80'(1'b1));
        check("post.id_inst", 80'(id_inst), 80'(32'h6666_0001));
        check("post.id_newpc", 80'(id_newpc), 80'(32'h50));
        check("post.bubble", 80'(bubble_count), 80'(16'd0));
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        step();
        check("post2.id_valid", 80'(id_valid), 80'(1'b0));
        check("post2.bubble", 80'(bubble_count), 80'(16'd1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
